// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serialises configuration words onto the ccff_head of the first tile of a
//   configuration chain. It produces the per-bit shift enable that gates
//   prog_clk, and holds IO_ISOL_N low from the start of a load until that load
//   completes cleanly.
//
// Ports
//   prog_clk   in   programming clock
//   pReset     in   asynchronous active-high reset
//   start      in   begin a load (sampled in IDLE only)
//   abort      in   cancel the load and return to IDLE (highest priority)
//   s_data     in   configuration word, MSB shifted first
//   s_valid    in   s_data valid
//   s_ready    out  block accepts s_data this cycle
//   ccff_head  out  serial configuration bit to the chain head
//   ccff_tail  in   serial bit returned from the chain tail
//   shift_en   out  chain captures ccff_head on this prog_clk edge
//   IO_ISOL_N  out  0 = IOs isolated, 1 = released after a good load
//   busy       out  FSM is not in IDLE
//   done       out  one-cycle pulse when the load completes
//   tail_ones  out  saturating count of 1s seen on ccff_tail while shift_en=1
//   dbg_state  out  current FSM state (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//
// Handshake: a word transfers on a prog_clk edge where s_valid and s_ready are
// both 1. s_ready is only high in LOAD and is withdrawn while abort is high, so
// no word is taken in an abort cycle. The source may hold or change s_data
// freely while s_ready is low.

module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 512,
    parameter int CNT_W     = 10
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones,
    output logic [1:0]        dbg_state
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WORD_W-1:0]  shreg_q;      // bits still to send, next-after-current at MSB
    logic [WB_W-1:0]    wbits_q;      // bits of the current word still to shift
    logic [CNT_W-1:0]   remaining_q;  // chain bits still to shift in this load
    logic [CNT_W-1:0]   tail_ones_q;
    logic               s_ready_q;
    logic               ccff_head_q;
    logic               shift_en_q;
    logic               iso_n_q;
    logic               busy_q;
    logic               done_q;

    // Every output is a flop (or a flop qualified by abort) so the prog_clk
    // gate driven from shift_en never sees decode glitches.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            wbits_q     <= '0;
            remaining_q <= '0;
            tail_ones_q <= '0;
            s_ready_q   <= 1'b0;
            ccff_head_q <= 1'b0;
            shift_en_q  <= 1'b0;
            iso_n_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            // The chain is left partially loaded, so the IOs stay isolated.
            state_q     <= S_IDLE;
            s_ready_q   <= 1'b0;
            ccff_head_q <= 1'b0;
            shift_en_q  <= 1'b0;
            iso_n_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // A shift edge samples whatever the chain tail presents.
            if (shift_en_q && ccff_tail && (tail_ones_q != {CNT_W{1'b1}})) begin
                tail_ones_q <= tail_ones_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_LOAD;
                        s_ready_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        iso_n_q     <= 1'b0;
                        tail_ones_q <= '0;
                        remaining_q <= CNT_W'(CHAIN_LEN);
                    end
                end
                S_LOAD: begin
                    if (s_valid && s_ready_q) begin
                        // The MSB goes out right away. On a short final word
                        // the low bits are dropped by limiting wbits.
                        state_q     <= S_SHIFT;
                        s_ready_q   <= 1'b0;
                        shift_en_q  <= 1'b1;
                        ccff_head_q <= s_data[WORD_W-1];
                        shreg_q     <= s_data << 1;
                        if (int'(remaining_q) < WORD_W) begin
                            wbits_q <= WB_W'(remaining_q);
                        end else begin
                            wbits_q <= WB_W'(WORD_W);
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_q     <= shreg_q << 1;
                    wbits_q     <= wbits_q - WB_W'(1);
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (wbits_q == WB_W'(1)) begin
                        shift_en_q  <= 1'b0;
                        ccff_head_q <= 1'b0;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD;
                            s_ready_q <= 1'b1;
                        end
                    end else begin
                        ccff_head_q <= shreg_q[WORD_W-1];
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    iso_n_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q & ~abort;
    assign ccff_head = ccff_head_q;
    assign shift_en  = shift_en_q;
    assign IO_ISOL_N = iso_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tail_ones = tail_ones_q;
    assign dbg_state = state_q;

endmodule
